// File: rtl/v850_pkg.sv
// -----------------------------------------------------------------------------
// v850_pkg
// Shared types and constants for the V850 writeback stage and register file.
//   XLEN_DEF / NREG_DEF / AW_DEF : default data width, register count, index width
//   word_t     : one general-register word
//   reg_idx_t  : general-register index
//   REG_ZERO   : index of the hardwired-zero register r0
//   wb_entry_t : one latched writeback result {valid, dest, data}
// -----------------------------------------------------------------------------
package v850_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int AW_DEF   = $clog2(NREG_DEF);

   typedef logic [XLEN_DEF-1:0] word_t;
   typedef logic [AW_DEF-1:0]   reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

   typedef struct packed {
      logic     valid;
      reg_idx_t dest;
      word_t    data;
   } wb_entry_t;

endpackage

// File: rtl/wb_regfile_multiport_sel.sv
// -----------------------------------------------------------------------------
// wb_priority_sel
// Looks up one register index among the NWR latched writeback entries.
// When several valid entries carry the same destination, the entry with the
// highest port index is returned.
// Ports:
//   ent_valid [NWR]        latched entry valid bits
//   ent_dest  [NWR][AW]    latched entry destinations
//   ent_data  [NWR][XLEN]  latched entry values
//   idx       [AW]         register index being looked up
//   hit                    some valid entry targets idx
//   data      [XLEN]       value of the winning entry (0 when no hit)
// -----------------------------------------------------------------------------
module wb_priority_sel
   import v850_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NWR  = 2,
   parameter int AW   = AW_DEF
) (
   input  logic [NWR-1:0]           ent_valid,
   input  logic [NWR-1:0][AW-1:0]   ent_dest,
   input  logic [NWR-1:0][XLEN-1:0] ent_data,
   input  logic [AW-1:0]            idx,
   output logic                     hit,
   output logic [XLEN-1:0]          data
);

   // Ascending scan: a later (higher) port overwrites an earlier match,
   // which yields the highest-index-wins rule.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int p = 0; p < NWR; p++) begin
         if (ent_valid[p] && (ent_dest[p] == idx)) begin
            hit  = 1'b1;
            data = ent_data[p];
         end
      end
   end

endmodule

// File: rtl/wb_regfile_multiport.sv
// -----------------------------------------------------------------------------
// wb_regfile_multiport
// Writeback stage and general-register file for the V850 core with NWR result
// ports and NRD combinational read ports.
//   Results presented at edge E are latched; they commit to the register file
//   at edge E+1. While latched they are forwarded to the read ports.
//   r0 always reads zero and is never written.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   wb_valid_i [NWR]      per-port result valid
//   wb_data_i  [NWR][XLEN] per-port result value
//   wb_dest_i  [NWR][AW]  per-port destination register
//   rd_addr_i  [NRD][AW]  read-port register index
//   rd_data_o  [NRD][XLEN] read-port data (with bypass from latched results)
//   sb_set_valid_i        issue marks sb_set_dest_i as having a producer in flight
//   sb_set_dest_i  [AW]   register to mark busy
//   busy_o     [NREG]     scoreboard, bit i = register i has a pending producer
//   wb_conflict_o         one-cycle pulse after a commit where two valid
//                         entries shared a destination
//   gr_o       [NREG][XLEN] full register view for debug/trace
// -----------------------------------------------------------------------------
module wb_regfile_multiport
   import v850_pkg::*;
#(
   parameter  int XLEN = XLEN_DEF,
   parameter  int NREG = NREG_DEF,
   parameter  int NWR  = 2,
   parameter  int NRD  = 3,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NWR-1:0]            wb_valid_i,
   input  logic [NWR-1:0][XLEN-1:0]  wb_data_i,
   input  logic [NWR-1:0][AW-1:0]    wb_dest_i,
   input  logic [NRD-1:0][AW-1:0]    rd_addr_i,
   output logic [NRD-1:0][XLEN-1:0]  rd_data_o,
   input  logic                      sb_set_valid_i,
   input  logic [AW-1:0]             sb_set_dest_i,
   output logic [NREG-1:0]           busy_o,
   output logic                      wb_conflict_o,
   output logic [NREG-1:0][XLEN-1:0] gr_o
);

   localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

   // A writable index is nonzero and below NREG (matters when NREG is not a
   // power of two and the index field can name registers that do not exist).
   function automatic logic idx_ok(input logic [AW-1:0] idx);
      return (idx != AW'(REG_ZERO)) && ({1'b0, idx} < NREG_LIM);
   endfunction

   // ---------------------------------------------------------------- latch
   logic [NWR-1:0]           lat_valid_reg;
   logic [NWR-1:0][AW-1:0]   lat_dest_reg;
   logic [NWR-1:0][XLEN-1:0] lat_data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_valid_reg <= '0;
         lat_dest_reg  <= '0;
         lat_data_reg  <= '0;
      end else begin
         for (int p = 0; p < NWR; p++) begin
            lat_valid_reg[p] <= wb_valid_i[p] && idx_ok(wb_dest_i[p]);
            lat_dest_reg[p]  <= wb_dest_i[p];
            lat_data_reg[p]  <= wb_data_i[p];
         end
      end
   end

   // --------------------------------------------------------------- commit
   // One selector per architectural register gives that register's write
   // enable and winning data; r0 has none since it is never written.
   logic [NREG-1:0]           cm_hit;
   logic [NREG-1:1][XLEN-1:0] cm_data;

   assign cm_hit[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_commit
         wb_priority_sel #(
            .XLEN (XLEN),
            .NWR  (NWR),
            .AW   (AW)
         ) u_commit_sel (
            .ent_valid (lat_valid_reg),
            .ent_dest  (lat_dest_reg),
            .ent_data  (lat_data_reg),
            .idx       (AW'(gi)),
            .hit       (cm_hit[gi]),
            .data      (cm_data[gi])
         );
      end
   endgenerate

   logic [NREG-1:0][XLEN-1:0] gr_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gr_reg <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (cm_hit[i]) begin
               gr_reg[i] <= cm_data[i];
            end
         end
      end
   end

   // ------------------------------------------------------------- conflict
   logic conflict_reg;
   logic conflict_next;

   // Latched valid entries never target r0, so any equal pair is a real clash.
   always_comb begin
      conflict_next = 1'b0;
      for (int p = 0; p < NWR; p++) begin
         for (int q = p + 1; q < NWR; q++) begin
            if (lat_valid_reg[p] && lat_valid_reg[q] &&
                (lat_dest_reg[p] == lat_dest_reg[q])) begin
               conflict_next = 1'b1;
            end
         end
      end
   end

   // ----------------------------------------------------------- scoreboard
   logic [NREG-1:0] busy_reg;
   logic [NREG-1:0] busy_next;

   // Clear first, then set: a new producer issued at the commit edge of the
   // previous one keeps the register busy.
   always_comb begin
      busy_next = busy_reg & ~cm_hit;
      if (sb_set_valid_i && idx_ok(sb_set_dest_i)) begin
         busy_next[sb_set_dest_i] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg     <= '0;
         conflict_reg <= 1'b0;
      end else begin
         busy_reg     <= busy_next;
         conflict_reg <= conflict_next;
      end
   end

   // ----------------------------------------------------------- read ports
   logic [NRD-1:0]           rd_hit;
   logic [NRD-1:0][XLEN-1:0] rd_byp;

   generate
      for (genvar gi = 0; gi < NRD; gi++) begin : g_read
         wb_priority_sel #(
            .XLEN (XLEN),
            .NWR  (NWR),
            .AW   (AW)
         ) u_read_sel (
            .ent_valid (lat_valid_reg),
            .ent_dest  (lat_dest_reg),
            .ent_data  (lat_data_reg),
            .idx       (rd_addr_i[gi]),
            .hit       (rd_hit[gi]),
            .data      (rd_byp[gi])
         );

         assign rd_data_o[gi] = !idx_ok(rd_addr_i[gi]) ? '0 :
                                rd_hit[gi]             ? rd_byp[gi] :
                                                         gr_reg[rd_addr_i[gi]];
      end
   endgenerate

   assign busy_o        = busy_reg;
   assign wb_conflict_o = conflict_reg;
   assign gr_o          = gr_reg;

endmodule

// File: tb/tb_wb_regfile_multiport.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile_multiport
// Directed scenarios followed by randomized traffic, compared every cycle
// against a behavioural model of the register file and scoreboard.
// -----------------------------------------------------------------------------
module tb_wb_regfile_multiport;
   import v850_pkg::*;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NWR  = 2;
   localparam int NRD  = 3;
   localparam int AW   = 5;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic [NWR-1:0]            wb_valid_i;
   logic [NWR-1:0][XLEN-1:0]  wb_data_i;
   logic [NWR-1:0][AW-1:0]    wb_dest_i;
   logic [NRD-1:0][AW-1:0]    rd_addr_i;
   logic [NRD-1:0][XLEN-1:0]  rd_data_o;
   logic                      sb_set_valid_i;
   logic [AW-1:0]             sb_set_dest_i;
   logic [NREG-1:0]           busy_o;
   logic                      wb_conflict_o;
   logic [NREG-1:0][XLEN-1:0] gr_o;

   wb_regfile_multiport #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NWR  (NWR),
      .NRD  (NRD)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wb_valid_i     (wb_valid_i),
      .wb_data_i      (wb_data_i),
      .wb_dest_i      (wb_dest_i),
      .rd_addr_i      (rd_addr_i),
      .rd_data_o      (rd_data_o),
      .sb_set_valid_i (sb_set_valid_i),
      .sb_set_dest_i  (sb_set_dest_i),
      .busy_o         (busy_o),
      .wb_conflict_o  (wb_conflict_o),
      .gr_o           (gr_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [XLEN-1:0] got,
                        input logic [XLEN-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%08h want=%08h", tag, got, want);
      end
   endtask

   // ------------------------------------------------------------- model
   // Architectural state: register contents, results waiting to commit,
   // busy flags and the conflict pulse.
   word_t     m_gr   [NREG];
   bit        m_busy [NREG];
   bit        m_conf;
   wb_entry_t m_lat  [NWR];

   function automatic void m_reset();
      for (int i = 0; i < NREG; i++) begin
         m_gr[i]   = '0;
         m_busy[i] = 1'b0;
      end
      for (int p = 0; p < NWR; p++) m_lat[p] = '0;
      m_conf = 1'b0;
   endfunction

   function automatic word_t m_read(input reg_idx_t a);
      if (a == 0) return '0;
      for (int p = NWR - 1; p >= 0; p--)
         if (m_lat[p].valid && m_lat[p].dest == a) return m_lat[p].data;
      return m_gr[a];
   endfunction

   // Effect of one clock edge given the inputs currently driven.
   function automatic void m_edge();
      int cnt [NREG];
      for (int i = 0; i < NREG; i++) cnt[i] = 0;
      for (int p = 0; p < NWR; p++) begin
         if (m_lat[p].valid) begin
            m_gr[m_lat[p].dest]   = m_lat[p].data;   // later port overwrites
            m_busy[m_lat[p].dest] = 1'b0;
            cnt[m_lat[p].dest]++;
         end
      end
      m_conf = 1'b0;
      for (int i = 0; i < NREG; i++) if (cnt[i] >= 2) m_conf = 1'b1;
      if (sb_set_valid_i && sb_set_dest_i != 0) m_busy[sb_set_dest_i] = 1'b1;
      for (int p = 0; p < NWR; p++) begin
         m_lat[p].valid = wb_valid_i[p] && (wb_dest_i[p] != 0);
         m_lat[p].dest  = wb_dest_i[p];
         m_lat[p].data  = wb_data_i[p];
      end
   endfunction

   task automatic compare_all();
      logic [NREG-1:0] mb;
      for (int i = 0; i < NREG; i++) mb[i] = m_busy[i];
      for (int r = 0; r < NRD; r++)
         check($sformatf("rd%0d@%0d", r, rd_addr_i[r]), rd_data_o[r], m_read(rd_addr_i[r]));
      check("busy", busy_o, mb);
      check("conflict", XLEN'(wb_conflict_o), XLEN'(m_conf));
      for (int i = 0; i < NREG; i++)
         check($sformatf("gr%0d", i), gr_o[i], m_gr[i]);
   endtask

   task automatic idle();
      wb_valid_i     = '0;
      wb_data_i      = '0;
      wb_dest_i      = '0;
      sb_set_valid_i = 1'b0;
      sb_set_dest_i  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
      compare_all();
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      idle();
      rd_addr_i = '0;
      m_reset();

      // Power-on reset, applied away from the clock edge.
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk) rst_n = 1'b1;

      // r5 = 0x1234 committed, r6 marked busy, r8 latched but not committed.
      wb_valid_i[0] = 1'b1; wb_dest_i[0] = 5'd5; wb_data_i[0] = 32'h1234;
      tick();
      idle();
      sb_set_valid_i = 1'b1; sb_set_dest_i = 5'd6;
      wb_valid_i[1] = 1'b1; wb_dest_i[1] = 5'd8; wb_data_i[1] = 32'hABCD;
      tick();
      check("r5_committed", gr_o[5], 32'h1234);
      check("r6_busy", XLEN'(busy_o[6]), 32'd1);
      idle();
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_gr5", gr_o[5], 32'h0);
      check("rst_busy", busy_o, 32'h0);
      check("rst_conflict", XLEN'(wb_conflict_o), 32'h0);
      compare_all();
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("rst_drops_r8", gr_o[8], 32'h0);

      // Latency and bypass.
      rd_addr_i[0] = 5'd3;
      wb_valid_i[0] = 1'b1; wb_dest_i[0] = 5'd3; wb_data_i[0] = 32'hDEADBEEF;
      tick();
      check("byp_r3", rd_data_o[0], 32'hDEADBEEF);
      check("r3_not_yet", gr_o[3], 32'h0);
      idle();
      tick();
      check("r3_committed", gr_o[3], 32'hDEADBEEF);

      // Writes to r0 from both ports: ignored, no conflict.
      rd_addr_i[1] = 5'd0;
      wb_valid_i = 2'b11; wb_dest_i[0] = 5'd0; wb_dest_i[1] = 5'd0;
      wb_data_i[0] = 32'h5555AAAA; wb_data_i[1] = 32'hFFFFFFFF;
      tick();
      check("r0_read", rd_data_o[1], 32'h0);
      idle();
      tick();
      check("r0_gr", gr_o[0], 32'h0);
      check("r0_noconf", XLEN'(wb_conflict_o), 32'h0);

      // Same destination on both ports.
      rd_addr_i[2] = 5'd7;
      wb_valid_i = 2'b11; wb_dest_i[0] = 5'd7; wb_dest_i[1] = 5'd7;
      wb_data_i[0] = 32'h11; wb_data_i[1] = 32'h22;
      tick();
      check("same_byp", rd_data_o[2], 32'h22);
      idle();
      tick();
      check("same_gr7", gr_o[7], 32'h22);
      check("conf_pulse", XLEN'(wb_conflict_o), 32'h1);
      tick();
      check("conf_drop", XLEN'(wb_conflict_o), 32'h0);

      // Scoreboard set/clear ordering.
      sb_set_valid_i = 1'b1; sb_set_dest_i = 5'd9;
      tick();
      check("sb_set9", XLEN'(busy_o[9]), 32'h1);
      idle();
      wb_valid_i[0] = 1'b1; wb_dest_i[0] = 5'd9; wb_data_i[0] = 32'h99;
      tick();
      idle();
      sb_set_valid_i = 1'b1; sb_set_dest_i = 5'd9;
      tick();
      check("sb_set_wins", XLEN'(busy_o[9]), 32'h1);
      idle();
      wb_valid_i[0] = 1'b1; wb_dest_i[0] = 5'd9; wb_data_i[0] = 32'h9A;
      tick();
      idle();
      tick();
      check("sb_clear9", XLEN'(busy_o[9]), 32'h0);
      sb_set_valid_i = 1'b1; sb_set_dest_i = 5'd0;
      tick();
      check("sb_r0", XLEN'(busy_o[0]), 32'h0);
      idle();

      // Back-to-back writes to r4.
      rd_addr_i[0] = 5'd4;
      for (int k = 1; k <= 3; k++) begin
         wb_valid_i[0] = 1'b1; wb_dest_i[0] = 5'd4; wb_data_i[0] = XLEN'(k);
         tick();
         check($sformatf("b2b_%0d", k), rd_data_o[0], XLEN'(k));
      end
      idle();
      tick();
      check("b2b_final", gr_o[4], 32'h3);

      // Randomized traffic, destinations biased to a few registers so that
      // bypass, conflicts and set/clear collisions occur often.
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < NWR; p++) begin
            wb_valid_i[p] = ($urandom_range(0, 3) != 0);
            wb_dest_i[p]  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1))
                                                        : AW'($urandom_range(0, 7));
            wb_data_i[p]  = $urandom;
         end
         for (int r = 0; r < NRD; r++)
            rd_addr_i[r] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1))
                                                       : AW'($urandom_range(0, 7));
         sb_set_valid_i = ($urandom_range(0, 2) == 0);
         sb_set_dest_i  = AW'($urandom_range(0, 7));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
